// File: rtl/radix2_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : radix2_divider_pkg
// Purpose  : Shared definitions for the RV32M iterative divider: opcode
//            encodings (funct3[1:0]), controller state type, data width.
// Revision : 1.0 - initial release
// ============================================================================
package radix2_divider_pkg;

    // Datapath width of the core
    localparam int unsigned C_DATA_WIDTH = 32;

    // Divide opcodes, taken directly from funct3[1:0]
    localparam logic [1:0] C_DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] C_DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] C_DIV_OP_REM  = 2'b10;
    localparam logic [1:0] C_DIV_OP_REMU = 2'b11;

    // Divider controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage : radix2_divider_pkg
`default_nettype wire

// File: rtl/radix2_divider_step.sv
`default_nettype none
// ============================================================================
// Module   : radix2_divider_step
// Purpose  : One combinational restoring-division iteration. Shifts the next
//            dividend bit into the partial remainder and subtracts the
//            divisor when it fits, producing one quotient bit.
// Revision : 1.0 - initial release
// ============================================================================
module radix2_divider_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_n,
    output logic [XLEN-1:0] quo_n
);

    // Trial subtraction is one bit wider so its MSB is a clean sign flag;
    // the partial remainder is always below the divisor, so no overflow.
    logic [XLEN:0] w_trial;

    // Restoring step: keep the difference when non-negative, else restore
    always_comb begin
        w_trial = {rem, quo[XLEN-1]} - {1'b0, divisor};
        if (!w_trial[XLEN]) begin
            rem_n = w_trial[XLEN-1:0];
            quo_n = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_n = {rem[XLEN-2:0], quo[XLEN-1]};
            quo_n = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule : radix2_divider_step
`default_nettype wire

// File: rtl/radix2_divider.sv
`default_nettype none
// ============================================================================
// Module   : radix2_divider
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//            behind the EX-stage req/stall/accept handshake. Divide-by-zero
//            and signed overflow resolve in a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
module radix2_divider
    import radix2_divider_pkg::*;
#(
    parameter int unsigned XLEN  = C_DATA_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            flush,
    input  logic            accept,
    input  logic [1:0]      opcode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] o,
    output logic            stall,
    output logic            busy
);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_divisor;
    logic [XLEN-1:0]  r_o;
    logic             r_is_rem;
    logic             r_q_neg;
    logic             r_r_neg;

    logic             w_signed;
    logic             w_is_rem;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_fast;
    logic [XLEN-1:0]  w_fast_res;
    logic             w_start;
    logic             w_step_en;
    logic             w_last;
    logic [XLEN-1:0]  w_rem_n;
    logic [XLEN-1:0]  w_quo_n;
    logic [XLEN-1:0]  w_final;

    // Operand decode and special-case detection on the incoming request
    assign w_signed   = (opcode == C_DIV_OP_DIV) | (opcode == C_DIV_OP_REM);
    assign w_is_rem   = (opcode == C_DIV_OP_REM) | (opcode == C_DIV_OP_REMU);
    assign w_abs_a    = (w_signed & a[XLEN-1]) ? -a : a;
    assign w_abs_b    = (w_signed & b[XLEN-1]) ? -b : b;
    assign w_div_zero = (b == '0);
    assign w_ovf      = w_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign w_fast     = w_div_zero | w_ovf;
    // Overflow: quotient is the dividend itself (most negative), remainder 0
    assign w_fast_res = w_div_zero ? (w_is_rem ? a : '1)
                                   : (w_is_rem ? '0 : a);

    assign w_start   = (r_state == ST_IDLE) & req & ~flush;
    assign w_step_en = (r_state == ST_BUSY) & req & ~flush;
    assign w_last    = (r_count == CNT_W'(XLEN - 1));

    radix2_divider_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .divisor (r_divisor),
        .rem_n   (w_rem_n),
        .quo_n   (w_quo_n)
    );

    // Sign correction uses the post-step values so the result lands with the last step
    assign w_final = r_is_rem ? (r_r_neg ? -w_rem_n : w_rem_n)
                              : (r_q_neg ? -w_quo_n : w_quo_n);

    assign o = r_o;

    // Controller state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs; flush overrides every state
    always_comb begin
        w_state_nxt = r_state;
        stall       = req & ~flush & (r_state != ST_DONE);
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (req & ~flush) begin
                    w_state_nxt = w_fast ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush | ~req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush | accept) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, fast-path result, and one iteration per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_o       <= '0;
            r_is_rem  <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_start) begin
            r_is_rem  <= w_is_rem;
            r_q_neg   <= w_signed & (a[XLEN-1] ^ b[XLEN-1]);
            r_r_neg   <= w_signed & a[XLEN-1];
            r_divisor <= w_abs_b;
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_count   <= '0;
            if (w_fast) begin
                r_o <= w_fast_res;
            end
        end else if (w_step_en) begin
            r_rem   <= w_rem_n;
            r_quo   <= w_quo_n;
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
                r_o <= w_final;
            end
        end else if (r_state == ST_BUSY) begin
            // Request withdrawn mid-operation: abandon the iteration
            r_count <= '0;
        end
    end

endmodule : radix2_divider
`default_nettype wire

// File: tb/tb_radix2_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_radix2_divider
// Purpose  : Self-checking bench for radix2_divider: directed RV32M cases,
//            handshake corner cases and randomized operands against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radix2_divider;

    localparam logic [1:0] c_div  = 2'b00;
    localparam logic [1:0] c_divu = 2'b01;
    localparam logic [1:0] c_rem  = 2'b10;
    localparam logic [1:0] c_remu = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        flush;
    logic        accept;
    logic [1:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic        stall;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    radix2_divider #(
        .XLEN  (32),
        .CNT_W (6)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .flush  (flush),
        .accept (accept),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .o      (o),
        .stall  (stall),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M result from plain 64-bit arithmetic (truncating division)
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx;
        longint sy;
        if (y == 32'd0) return op[1] ? x : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return op[1] ? 32'(sx % sy) : 32'(sx / sy);
        end
        return op[1] ? (x % y) : (x / y);
    endfunction

    // Expected number of stalled cycles seen by EX
    function automatic int ref_stall(input logic [1:0] op, input logic [31:0] x,
                                     input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Count stalled cycles from the next falling edge until stall drops (bounded)
    task automatic wait_done(output int n);
        n = 0;
        while (n <= 200) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
    endtask

    task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y);
        int n;
        @(posedge clk);
        #1;
        req    = 1'b1;
        opcode = op;
        a      = x;
        b      = y;
        accept = 1'b0;
        wait_done(n);
        check({tag, " o"}, o, ref_result(op, x, y));
        check({tag, " stall_cycles"}, 32'(n), 32'(ref_stall(op, x, y)));
        accept = 1'b1;
        @(posedge clk);
        #1;
        req    = 1'b0;
        accept = 1'b0;
    endtask

    initial begin
        int          n;
        logic [1:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [31:0] held;

        rst    = 1'b0;
        req    = 1'b0;
        flush  = 1'b0;
        accept = 1'b0;
        opcode = 2'b00;
        a      = '0;
        b      = '0;
        #12;
        check("reset o", o, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed arithmetic and special cases
        do_div("divu 100/7", c_divu, 32'd100, 32'd7);
        do_div("remu 100/7", c_remu, 32'd100, 32'd7);
        do_div("div -100/7", c_div, 32'hFFFF_FF9C, 32'd7);
        do_div("rem -100/7", c_rem, 32'hFFFF_FF9C, 32'd7);
        do_div("divu by 0", c_divu, 32'h1234_5678, 32'd0);
        do_div("remu by 0", c_remu, 32'h1234_5678, 32'd0);
        do_div("div by 0", c_div, 32'h8765_4321, 32'd0);
        do_div("div ovf", c_div, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("rem ovf", c_rem, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu ovf-ops", c_divu, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("div 7/-2", c_div, 32'd7, 32'hFFFF_FFFE);
        do_div("rem 7/-2", c_rem, 32'd7, 32'hFFFF_FFFE);
        do_div("divu max/1", c_divu, 32'hFFFF_FFFF, 32'd1);

        // Flush at BUSY step 10
        @(posedge clk);
        #1;
        req    = 1'b1;
        opcode = c_divu;
        a      = 32'd1000;
        b      = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush stall", {31'd0, stall}, 32'd0);
        check("flush busy before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        check("flush busy after", {31'd0, busy}, 32'd0);
        do_div("divu 9/3 post-flush", c_divu, 32'd9, 32'd3);

        // Hold in DONE with accept low, then accept with a new request waiting
        @(posedge clk);
        #1;
        req    = 1'b1;
        opcode = c_divu;
        a      = 32'd1000;
        b      = 32'd7;
        wait_done(n);
        check("hold first o", o, 32'd142);
        held = o;
        repeat (5) begin
            @(negedge clk);
            check("hold o stable", o, held);
            check("hold stall low", {31'd0, stall}, 32'd0);
        end
        accept = 1'b1;
        a      = 32'd8;
        b      = 32'd2;
        @(posedge clk);
        #1;
        accept = 1'b0;
        wait_done(n);
        check("b2b divu 8/2 o", o, 32'd4);
        check("b2b stall_cycles", 32'(n), 32'd33);

        // Asynchronous reset mid-BUSY
        accept = 1'b1;
        @(posedge clk);
        #1;
        accept = 1'b0;
        a      = 32'd50;
        b      = 32'd5;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        req = 1'b0;
        #1;
        check("async rst o", o, 32'd0);
        check("async rst stall", {31'd0, stall}, 32'd0);
        check("async rst busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_div("div post-reset", c_div, 32'hFFFF_FC18, 32'd10);

        // Randomized operands with a bias toward corner divisors
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            rx  = $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 15));
                2: begin
                    ry = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 1) == 1) rx = 32'h8000_0000;
                end
                3:       ry = 32'h8000_0000 | $urandom;
                default: ry = $urandom;
            endcase
            do_div($sformatf("rand%0d op%0d", i, rop), rop, rx, ry);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_radix2_divider
`default_nettype wire

// File: doc/radix2_divider.md
Name: radix2_divider

Overview:
- Iterative restoring divider that serves the EX stage's divide request/stall interface for RV32M DIV, DIVU, REM and REMU.
- EX raises req while a divide sits in the stage. This block holds stall high until the result is ready, presents the result on o, and waits for accept before it will take the next request.
- Architectural special cases (divide by zero, signed overflow) are resolved on a one-cycle fast path.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > XLEN)

Ports:
clk      input   1     core clock
rst      input   1     asynchronous reset, active-low (0 = reset)
req      input   1     divide request from EX; held high until accept
flush    input   1     EX flush; aborts any operation
accept   input   1     EX stage advance; consumes the result presented in DONE
opcode   input   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
a        input   XLEN  dividend (rs1, forwarded)
b        input   XLEN  divisor (rs2, forwarded)
o        output  XLEN  result; valid while in DONE
stall    output  1     divide not complete; EX must hold
busy     output  1     state != IDLE (debug/perf)

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, o=0, internal regs=0, stall=0, busy=0.
- States: IDLE, BUSY, DONE.
- stall = req & ~flush & (state != DONE). This is combinational, so stall is high in the same cycle req first rises.
- IDLE, req=1 & flush=0:
  - Latch abs(a) and abs(b); abs applies only for signed ops (DIV, REM).
  - Latch opcode, q_neg = a[31]^b[31] (signed only) and r_neg = a[31] (signed only).
- IDLE fast path (sampled the same cycle):
  - b==0: o <= all ones (DIV/DIVU) or a (REM/REMU); go DONE.
  - DIV with a=0x80000000, b=0xFFFFFFFF: o <= 0x80000000; go DONE.
  - REM with the same operands: o <= 0; go DONE.
  - Fast-path stall is high for 1 cycle; result visible in cycle 2.
- IDLE normal path: rem=0, quo=abs(a), count=0; go BUSY.
- BUSY, each cycle (one restoring step):
  - t = {rem[XLEN-1:0], quo[XLEN-1]} - {1'b0, divisor}.
  - If t is non-negative: rem <= t[XLEN-1:0], quo <= {quo[XLEN-2:0],1}.
  - Otherwise: rem <= {rem[XLEN-2:0], quo[XLEN-1]}, quo <= {quo[XLEN-2:0],0}.
  - count++.
  - At the step where count==XLEN-1, load o with the sign-corrected result:
    - DIV/DIVU: q_neg ? -quo' : quo'
    - REM/REMU: r_neg ? -rem' : rem'
    - (quo'/rem' are the values after the final step.)
  - Then go DONE.
- Latency (normal path): stall high for 1 + XLEN = 33 cycles; o valid and stall=0 in cycle 34.
- DONE: o stable, stall=0.
  - accept=1 → IDLE; a new req is sampled in IDLE on the following cycle.
  - accept=0 → remain in DONE (EX stalled by another source).
  - Back-to-back divides: a second divide costs one IDLE cycle (stall high) before it starts.
- flush=1 in any state: next state IDLE, count=0; stall is 0 in that same cycle. o holds its value (don't-care).
- req falling in BUSY without flush: abort to IDLE (defensive).
- Arithmetic: all subtraction in XLEN+1 bits; negation is two's complement modulo 2^XLEN; unsigned ops never negate.

Decomposition:
- Shared core package/header:
  - DIV_OP_DIV/DIVU/REM/REMU 2-bit constants.
  - div_state_t enum {IDLE, BUSY, DONE}.
  - XLEN alias of `DATA_RANGE width.
- One natural sub-module: div_step, the combinational single restoring iteration (rem, quo, divisor → rem_n, quo_n). Keeping it separate lets a radix-4 variant instantiate two steps per cycle.

Test Plan:
- DIVU a=100, b=7: req held → stall=1 for 33 cycles, o=14 on cycle 34; same run with REMU → o=2.
- DIV a=-100 (0xFFFFFF9C), b=7 → o=0xFFFFFFF2 (-14); REM same operands → o=0xFFFFFFFE (-2).
- Divide by zero, b=0, a=0x12345678: DIVU → o=0xFFFFFFFF and REMU → o=0x12345678, each with stall high exactly 1 cycle.
- Overflow a=0x80000000, b=0xFFFFFFFF: DIV → o=0x80000000; REM → o=0; 1-cycle stall.
- Assert flush at BUSY step 10 → stall=0 that cycle, busy=0 next cycle. A following DIVU 9/3 → o=3 with full 33-cycle stall and no stale state.
- Hold accept=0 for 5 cycles in DONE → o stable, stall=0. Assert accept while a new req (DIVU 8/2) is present → IDLE then BUSY, o=4. Also assert rst=0 mid-BUSY → all outputs 0 immediately.
